// File: rtl/elevator_pkg.sv
// Shared types and constants for the N-floor elevator controller.
// Holds the controller state encoding, motor-direction and door command
// codes, and small decode helpers that turn a state into actuator commands.
package elevator_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPEN    = 3'd1,
    CLOSING = 3'd2,
    MOVE_UP = 3'd3,
    MOVE_DN = 3'd4,
    FAULT   = 3'd5
  } state_e;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam logic DOOR_OPEN_CLOSE = 1'b1;
  localparam logic DOOR_OPEN_OPEN  = 1'b0;

  function automatic logic [1:0] state_dir(input state_e s);
    case (s)
      MOVE_UP: state_dir = DIR_UP;
      MOVE_DN: state_dir = DIR_DN;
      default: state_dir = DIR_IDLE;
    endcase
  endfunction

  function automatic logic state_door(input state_e s);
    state_door = (s == OPEN) ? DOOR_OPEN_OPEN : DOOR_OPEN_CLOSE;
  endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-request registers for hall-up, hall-down and car calls.
// Each floor bit is set by its button and cleared by a floor-addressed clear;
// when both happen in the same cycle the clear wins.
// Also reduces the pending bits relative to a reference floor.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   up_req/dn_req/car_req    raw call inputs (bit k-1 = floor k)
//   clr, clr_floor           clear all three call bits at clr_floor
//   ref_floor                floor used for above/below/here reductions
//   pend_up/pend_dn/pend_car registered pending bits
//   above, below             any call strictly above / below ref_floor
//   here, here_up/dn/car     calls at ref_floor (combined and per vector)
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FS_W       = $clog2(NUM_FLOORS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] up_req,
  input  logic [NUM_FLOORS-1:0] dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic                  clr,
  input  logic [FS_W-1:0]       clr_floor,
  input  logic [FS_W-1:0]       ref_floor,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic                  above,
  output logic                  below,
  output logic                  here,
  output logic                  here_up,
  output logic                  here_dn,
  output logic                  here_car
);

  logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
  logic [NUM_FLOORS-1:0] pend_dn_q, pend_dn_d;
  logic [NUM_FLOORS-1:0] pend_car_q, pend_car_d;
  logic [NUM_FLOORS-1:0] up_m, dn_m, clr_vec;

  always_comb begin
    // no up call exists at the top floor, no down call at floor 1
    up_m                 = up_req;
    up_m[NUM_FLOORS-1]   = 1'b0;
    dn_m                 = dn_req;
    dn_m[0]              = 1'b0;
    clr_vec              = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      clr_vec[k] = clr && (clr_floor == FS_W'(k + 1));
    end
    pend_up_d  = (pend_up_q  | up_m)    & ~clr_vec;
    pend_dn_d  = (pend_dn_q  | dn_m)    & ~clr_vec;
    pend_car_d = (pend_car_q | car_req) & ~clr_vec;
  end

  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    here_up  = 1'b0;
    here_dn  = 1'b0;
    here_car = 1'b0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (FS_W'(k + 1) > ref_floor)
        above = above | pend_up_q[k] | pend_dn_q[k] | pend_car_q[k];
      if (FS_W'(k + 1) < ref_floor)
        below = below | pend_up_q[k] | pend_dn_q[k] | pend_car_q[k];
      if (FS_W'(k + 1) == ref_floor) begin
        here_up  = pend_up_q[k];
        here_dn  = pend_dn_q[k];
        here_car = pend_car_q[k];
      end
    end
    here = here_up | here_dn | here_car;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_up_q  <= '0;
      pend_dn_q  <= '0;
      pend_car_q <= '0;
    end else begin
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      pend_car_q <= pend_car_d;
    end
  end

  assign pend_up  = pend_up_q;
  assign pend_dn  = pend_dn_q;
  assign pend_car = pend_car_q;

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches calls, serves them in SCAN order,
// commands door and motor direction, and latches a sticky fault on a
// travel watchdog timeout or an out-of-range floor sensor value.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   up_req/dn_req/car_req     hall up, hall down and in-car call buttons
//   fs                        floor sensor (0 = between floors, k = floor k)
//   dc                        door-closed sensor, only looked at while closing
//   door                      1 = close/keep closed, 0 = open
//   dir                       00 idle, 01 up, 10 down
//   cur_floor                 last valid floor seen
//   pend_up/pend_dn/pend_car  pending-request lamps
//   fault                     sticky fault, cleared only by reset
//
// state   | meaning
// CLOSED  | parked, door closed, waiting for a call
// OPEN    | door open, door timer running
// CLOSING | door commanded closed, waiting for dc before moving
// MOVE_UP | travelling up, watchdog running
// MOVE_DN | travelling down, watchdog running
// FAULT   | stopped with door closed until reset
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS       = 4,
  parameter int DOOR_OPEN_CYCLES = 4,
  parameter int MOVE_TIMEOUT     = 64,
  parameter int FS_W             = $clog2(NUM_FLOORS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] up_req,
  input  logic [NUM_FLOORS-1:0] dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FS_W-1:0]       fs,
  input  logic                  dc,
  output logic                  door,
  output logic [1:0]            dir,
  output logic [FS_W-1:0]       cur_floor,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic                  fault
);

  localparam int DT_W = $clog2(DOOR_OPEN_CYCLES + 1);
  localparam int WD_W = $clog2(MOVE_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [DT_W-1:0]   door_tmr_q, door_tmr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pref_up_q, pref_up_d;
  logic [FS_W-1:0]   cur_floor_q, cur_floor_d;
  logic              door_q, door_d;
  logic [1:0]        dir_q, dir_d;
  logic              fault_q, fault_d;

  logic fs_bad, fs_valid, at_top, at_bot, open_entry, clr;
  logic above, below, here, here_up, here_dn, here_car;

  always_comb begin
    fs_bad      = (fs > FS_W'(NUM_FLOORS));
    fs_valid    = (fs != '0) && !fs_bad;
    cur_floor_d = fs_valid ? fs : cur_floor_q;
    at_top      = (cur_floor_d == FS_W'(NUM_FLOORS));
    at_bot      = (cur_floor_d == FS_W'(1));
  end

  // Reductions use the floor being reached this cycle, so a move state sees
  // the calls relative to fs and the stop clears the floor just arrived at.
  elevator_req_reg #(
    .NUM_FLOORS (NUM_FLOORS),
    .FS_W       (FS_W)
  ) u_req (
    .clk       (clk),
    .rst       (rst),
    .up_req    (up_req),
    .dn_req    (dn_req),
    .car_req   (car_req),
    .clr       (clr),
    .clr_floor (cur_floor_d),
    .ref_floor (cur_floor_d),
    .pend_up   (pend_up),
    .pend_dn   (pend_dn),
    .pend_car  (pend_car),
    .above     (above),
    .below     (below),
    .here      (here),
    .here_up   (here_up),
    .here_dn   (here_dn),
    .here_car  (here_car)
  );

  always_comb begin
    state_d    = state_q;
    door_tmr_d = door_tmr_q;
    wd_d       = wd_q;
    pref_up_d  = pref_up_q;

    if (fs_bad) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        CLOSED: begin
          if (here)                state_d = OPEN;
          else if (above || below) state_d = CLOSING;
        end
        OPEN: begin
          if (here) begin
            door_tmr_d = DT_W'(DOOR_OPEN_CYCLES);
          end else if (door_tmr_q <= DT_W'(1)) begin
            state_d    = CLOSING;
            door_tmr_d = '0;
          end else begin
            door_tmr_d = door_tmr_q - DT_W'(1);
          end
        end
        CLOSING: begin
          if (here) begin
            state_d = OPEN;
          end else if (dc) begin
            if (above && (pref_up_q || !below)) begin
              state_d   = MOVE_UP;
              pref_up_d = 1'b1;
              wd_d      = WD_W'(MOVE_TIMEOUT);
            end else if (below) begin
              state_d   = MOVE_DN;
              pref_up_d = 1'b0;
              wd_d      = WD_W'(MOVE_TIMEOUT);
            end else begin
              state_d = CLOSED;
            end
          end
        end
        MOVE_UP: begin
          if (fs == '0) begin
            if (wd_q <= WD_W'(1)) begin
              state_d = FAULT;
              wd_d    = '0;
            end else begin
              wd_d = wd_q - WD_W'(1);
            end
          end else if (here_car || here_up || !above || at_top) begin
            state_d = OPEN;
            wd_d    = '0;
          end else begin
            wd_d = WD_W'(MOVE_TIMEOUT);
          end
        end
        MOVE_DN: begin
          if (fs == '0) begin
            if (wd_q <= WD_W'(1)) begin
              state_d = FAULT;
              wd_d    = '0;
            end else begin
              wd_d = wd_q - WD_W'(1);
            end
          end else if (here_car || here_dn || !below || at_bot) begin
            state_d = OPEN;
            wd_d    = '0;
          end else begin
            wd_d = WD_W'(MOVE_TIMEOUT);
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end

    // Any arrival in OPEN restarts the full dwell; a here call while open
    // is served by clearing it and extending the dwell above.
    open_entry = (state_d == OPEN) && (state_q != OPEN);
    if (open_entry) door_tmr_d = DT_W'(DOOR_OPEN_CYCLES);
    clr = (state_d == OPEN) && (open_entry || here);

    door_d  = state_door(state_d);
    dir_d   = state_dir(state_d);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CLOSED;
      door_tmr_q  <= '0;
      wd_q        <= '0;
      pref_up_q   <= 1'b1;
      cur_floor_q <= FS_W'(1);
      door_q      <= DOOR_OPEN_CLOSE;
      dir_q       <= DIR_IDLE;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      door_tmr_q  <= door_tmr_d;
      wd_q        <= wd_d;
      pref_up_q   <= pref_up_d;
      cur_floor_q <= cur_floor_d;
      door_q      <= door_d;
      dir_q       <= dir_d;
      fault_q     <= fault_d;
    end
  end

  assign door      = door_q;
  assign dir       = dir_q;
  assign cur_floor = cur_floor_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
module tb_elevator_ctrl_n;

  localparam int NF = 4;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] up_req, dn_req, car_req;
  logic [FW-1:0] fs;
  logic          dc;
  logic          door;
  logic [1:0]    dir;
  logic [FW-1:0] cur_floor;
  logic [NF-1:0] pend_up, pend_dn, pend_car;
  logic          fault;

  int checks   = 0;
  int failures = 0;

  elevator_ctrl_n #(
    .NUM_FLOORS       (NF),
    .DOOR_OPEN_CYCLES (4),
    .MOVE_TIMEOUT     (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_req    (up_req),
    .dn_req    (dn_req),
    .car_req   (car_req),
    .fs        (fs),
    .dc        (dc),
    .door      (door),
    .dir       (dir),
    .cur_floor (cur_floor),
    .pend_up   (pend_up),
    .pend_dn   (pend_dn),
    .pend_car  (pend_car),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dir(input logic [1:0] want, input int budget, input string tag);
    int n;
    n = 0;
    while (dir !== want && n < budget) begin
      step();
      n++;
    end
    chk(tag, {30'd0, dir}, {30'd0, want});
  endtask

  task automatic do_reset(input logic [FW-1:0] floor);
    rst = 1'b0;
    fs  = floor;
    up_req = '0; dn_req = '0; car_req = '0;
    steps(2);
    rst = 1'b1;
  endtask

  initial begin
    dc = 1'b0;
    do_reset(3'd1);

    // reset state
    chk("rst_door", door, 1);
    chk("rst_dir", dir, 0);
    chk("rst_floor", cur_floor, 1);
    chk("rst_pend_up", pend_up, 0);
    chk("rst_pend_dn", pend_dn, 0);
    chk("rst_pend_car", pend_car, 0);
    chk("rst_fault", fault, 0);

    // hall up call at the current floor opens the door two edges later
    up_req = 4'b0001;
    step();
    up_req = '0;
    chk("t1_latch", pend_up, 4'b0001);
    chk("t1_door_still_closed", door, 1);
    step();
    chk("t1_open", door, 0);
    chk("t1_open_dir", dir, 0);
    chk("t1_clear", pend_up, 0);
    steps(3);
    chk("t1_open_4th", door, 0);
    step();
    chk("t1_closing", door, 1);

    // car call to floor 3, pass floor 2, stop at 3
    car_req = 4'b0100;
    step();
    car_req = '0;
    chk("t2_latch", pend_car, 4'b0100);
    dc = 1'b1;
    step();
    chk("t2_move_up", dir, 2'b01);
    chk("t2_move_door", door, 1);
    dc = 1'b0;
    fs = 3'd0; step();
    fs = 3'd2; step();
    chk("t2_pass2_dir", dir, 2'b01);
    chk("t2_pass2_floor", cur_floor, 2);
    fs = 3'd0; step();
    fs = 3'd3; step();
    chk("t2_stop3_door", door, 0);
    chk("t2_stop3_dir", dir, 0);
    chk("t2_stop3_floor", cur_floor, 3);
    chk("t2_stop3_clear", pend_car, 0);

    // reopen from CLOSING with a full dwell
    steps(4);
    chk("t4_closing", door, 1);
    car_req = 4'b0100;
    step();
    car_req = '0;
    chk("t4_latch_closed", door, 1);
    step();
    chk("t4_reopen", door, 0);
    chk("t4_reopen_clear", pend_car, 0);
    steps(3);
    chk("t4_full_dwell", door, 0);
    step();
    chk("t4_closed_again", door, 1);

    // SCAN from floor 2: stop at 3 (hall up), continue to 4, reverse to 1
    do_reset(3'd2);
    step();
    chk("t3_floor2", cur_floor, 2);
    car_req = 4'b1000;
    up_req  = 4'b0001;
    step();
    car_req = '0; up_req = '0;
    dc = 1'b1;
    step();
    chk("t3_closing", door, 1);
    step();
    chk("t3_up", dir, 2'b01);
    fs = 3'd0; step();
    up_req = 4'b0100;
    step();
    up_req = '0;
    fs = 3'd3; step();
    chk("t3_stop3_door", door, 0);
    chk("t3_stop3_floor", cur_floor, 3);
    chk("t3_stop3_up", pend_up, 4'b0001);
    chk("t3_stop3_car", pend_car, 4'b1000);
    steps(4);
    chk("t3_close3", door, 1);
    step();
    chk("t3_up_again", dir, 2'b01);
    fs = 3'd0; step();
    fs = 3'd4; step();
    chk("t3_stop4_door", door, 0);
    chk("t3_stop4_floor", cur_floor, 4);
    chk("t3_stop4_car", pend_car, 0);
    steps(4);
    step();
    chk("t3_reverse", dir, 2'b10);
    fs = 3'd0; step();
    fs = 3'd3; step();
    chk("t3_pass3_dir", dir, 2'b10);
    chk("t3_pass3_floor", cur_floor, 3);
    fs = 3'd0; step();
    fs = 3'd2; step();
    chk("t3_pass2_dir", dir, 2'b10);
    fs = 3'd0; step();
    fs = 3'd1; step();
    chk("t3_stop1_door", door, 0);
    chk("t3_stop1_floor", cur_floor, 1);
    chk("t3_stop1_up", pend_up, 0);

    // watchdog: fs held 0 while moving
    car_req = 4'b1000;
    step();
    car_req = '0;
    wait_dir(2'b01, 10, "t5_depart");
    fs = 3'd0;
    steps(63);
    chk("t5_no_fault_63", fault, 0);
    chk("t5_dir_63", dir, 2'b01);
    step();
    chk("t5_fault", fault, 1);
    chk("t5_fault_dir", dir, 0);
    chk("t5_fault_door", door, 1);
    fs = 3'd1;
    car_req = 4'b0001;
    steps(3);
    car_req = '0;
    chk("t5_sticky", fault, 1);
    chk("t5_sticky_door", door, 1);

    // invalid floor sensor value while parked
    do_reset(3'd1);
    step();
    chk("t5b_ok", fault, 0);
    fs = 3'd7;
    step();
    chk("t5b_fault", fault, 1);
    chk("t5b_door", door, 1);
    chk("t5b_dir", dir, 0);

    // top-floor up and floor-1 down hall bits are ignored
    do_reset(3'd1);
    up_req = 4'b1000;
    dn_req = 4'b0001;
    step();
    up_req = '0; dn_req = '0;
    chk("t7_up_ignored", pend_up, 0);
    chk("t7_dn_ignored", pend_dn, 0);
    step();
    chk("t7_stay_closed", door, 1);
    chk("t7_stay_idle", dir, 0);

    // reset mid-move drops everything
    car_req = 4'b1000;
    dn_req  = 4'b0100;
    dc = 1'b1;
    step();
    car_req = '0; dn_req = '0;
    chk("t6_latch_dn", pend_dn, 4'b0100);
    step();
    step();
    chk("t6_up", dir, 2'b01);
    fs = 3'd0; step();
    fs = 3'd2; step();
    fs = 3'd3; step();
    chk("t6_pass3_floor", cur_floor, 3);
    chk("t6_pass3_dir", dir, 2'b01);
    fs = 3'd0;
    rst = 1'b0;
    step();
    chk("t6_dir", dir, 0);
    chk("t6_door", door, 1);
    chk("t6_floor", cur_floor, 1);
    chk("t6_pend_car", pend_car, 0);
    chk("t6_pend_dn", pend_dn, 0);
    chk("t6_fault", fault, 0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
